tcs34725_sequencer: RTL and testbench
=====================================

// Module: tcs34725_sequencer
// PURPOSE
//  Master controller for the TCS34725 colour sensor. It sequences a single-register
//  I2C byte engine to power up and configure the sensor, polls for a valid
//  conversion, and reads the 8 colour-data bytes. It assembles the bytes into
//  16-bit C/R/G/B words and publishes them atomically to the display/processing logic.
//  It sits between top-level control and the I2C byte engine; that engine drives
//  scl_i2c/sda.
// PARAMETERS
//  ATIME_VAL   8'hF6    value written to ATIME (0x01)
//  PON_WAIT    120000   cycles idle after PON before enabling AEN (>=2.4 ms)
//  POLL_GAP    50000    cycles between STATUS polls while AVALID=0
//  TIMEOUT     200000   max cycles from i2c_req to i2c_done/i2c_err
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  run          in   1   level; 1 = measure continuously, 0 = return to IDLE
//  i2c_req      out  1   one-cycle pulse starting one engine transaction
//  i2c_rw       out  1   0 = write register, 1 = read register
//  i2c_cmd      out  8   command byte = 8'h80 | register address
//  i2c_wdata    out  8   write data (ignored on reads)
//  i2c_rdata    in   8   read data, valid in the i2c_done cycle
//  i2c_done     in   1   one-cycle pulse: transaction completed with ACKs
//  i2c_err      in   1   one-cycle pulse: NACK/bus failure
//  clear_o      out  16  latest clear word
//  red_o        out  16  latest red word
//  green_o      out  16  latest green word
//  blue_o       out  16  latest blue word
//  color_valid  out  1   one-cycle pulse when all four words update
//  busy         out  1   1 in any state except IDLE and FAULT
//  fault        out  1   sticky error flag
// BEHAVIOUR
//  Reset values: all outputs 0, i2c_cmd/i2c_wdata 0, FSM in IDLE, timers 0.
//  Transaction rule:
//  - Each register access issues i2c_req for exactly 1 cycle.
//  - i2c_rw, i2c_cmd and i2c_wdata are driven the same cycle and held stable until done/err.
//  - The FSM waits in a WAIT sub-state; only one transaction is outstanding at a time.
//  - i2c_done/i2c_err seen outside WAIT are ignored.
//  - If done and err arrive in the same cycle, err wins.
//  - A timeout counter starts at req; reaching TIMEOUT counts as err.
//  - Any err -> FAULT: fault=1, busy=0. FAULT is left only when run=0 (-> IDLE, fault cleared).
//  States / transitions:
//  - IDLE:    run=1 -> WR_PON.
//  - WR_PON:  write 0x00 <- 8'h01; done -> PON_DLY.
//  - PON_DLY: count PON_WAIT cycles -> WR_ATIME.
//  - WR_ATIME: write 0x01 <- ATIME_VAL; done -> WR_AEN.
//  - WR_AEN:  write 0x00 <- 8'h03; done -> POLL.
//  - POLL:    read 0x13; done with rdata[0]=1 -> RD_DATA, idx=0; rdata[0]=0 -> GAP.
//  - GAP:     count POLL_GAP cycles -> POLL.
//  - RD_DATA: read register 0x14+idx for idx 0..7 (CL,CH,RL,RH,GL,GH,BL,BH).
//    Each byte goes into a shadow register, low byte first. idx 7 done -> PUBLISH.
//  - PUBLISH: copy all shadows to outputs and pulse color_valid in this single cycle.
//    Then: run=1 -> POLL (sensor already enabled); run=0 -> IDLE.
//  Other rules:
//  - run=0 in any non-FAULT state: finish the outstanding transaction, then go to IDLE.
//    No PUBLISH occurs for a partial frame; outputs keep their last published values.
//  - Timers go to IDLE at once when run=0.
//  - Output words never mix bytes from two frames.
//  - idx is 3 bits and never wraps mid-frame.
//  - rst mid-transaction: immediate return to reset state. Later done/err pulses
//    from the engine are ignored by the IDLE rule.
// TESTING
//  - Startup: rst, run=1, engine model acks every req.
//    -> writes in order (00,01),(01,F6),(00,03); gap >= PON_WAIT after the first.
//  - Poll: STATUS returns 00,00,01.
//    -> three 0x93 reads, each gap >= POLL_GAP, then 8 reads cmd 0x94..0x9B.
//  - Data: bytes 11,22,33,44,55,66,77,88.
//    -> clear=2211, red=4433, green=6655, blue=8877; one color_valid pulse.
//  - NACK on WR_ATIME -> fault=1, busy=0, no further req.
//    run=0 clears fault; run=1 restarts at WR_PON.
//  - Engine never answers on read 0x16 -> fault set exactly TIMEOUT cycles after req.
//    Outputs keep the previous frame.
//  - run dropped during RD_DATA idx=3 -> that read completes, no color_valid, IDLE, busy=0.
//    Same-cycle done+err -> FAULT.

Source files
------------

// File: rtl/tcs34725_sequencer.sv
// TCS34725 sequencer: powers up and configures the sensor, polls STATUS.AVALID,
// reads CDATA..BDATAH through a one-register I2C byte engine, publishes C/R/G/B atomically.
module tcs34725_sequencer #(
  parameter logic [7:0]  ATIME_VAL = 8'hF6,
  parameter int unsigned PON_WAIT  = 120000,
  parameter int unsigned POLL_GAP  = 50000,
  parameter int unsigned TIMEOUT   = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        i2c_req,
  output logic        i2c_rw,
  output logic [7:0]  i2c_cmd,
  output logic [7:0]  i2c_wdata,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_done,
  input  logic        i2c_err,
  output logic [15:0] clear_o,
  output logic [15:0] red_o,
  output logic [15:0] green_o,
  output logic [15:0] blue_o,
  output logic        color_valid,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PON,
    S_PON_DLY,
    S_WR_ATIME,
    S_WR_AEN,
    S_POLL,
    S_GAP,
    S_RD_DATA,
    S_PUBLISH,
    S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic             wait_q, wait_d;
  logic [31:0]      tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0][7:0]  shd_q, shd_d;
  logic [63:0]      col_q, col_d;
  logic             cv_q, cv_d;
  logic             req_q, req_d;
  logic             rw_q, rw_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       wdata_q, wdata_d;

  logic             acc_st;
  logic             acc_rw;
  logic [7:0]       acc_reg;
  logic [7:0]       acc_wdata;
  logic             tmo;
  logic             txn_err;
  logic             txn_done;

  // Register access performed by the current state (if any).
  always_comb begin
    acc_st    = 1'b0;
    acc_rw    = 1'b0;
    acc_reg   = 8'h00;
    acc_wdata = 8'h00;
    case (state_q)
      S_WR_PON: begin
        acc_st    = 1'b1;
        acc_reg   = 8'h00;
        acc_wdata = 8'h01;
      end
      S_WR_ATIME: begin
        acc_st    = 1'b1;
        acc_reg   = 8'h01;
        acc_wdata = ATIME_VAL;
      end
      S_WR_AEN: begin
        acc_st    = 1'b1;
        acc_reg   = 8'h00;
        acc_wdata = 8'h03;
      end
      S_POLL: begin
        acc_st  = 1'b1;
        acc_rw  = 1'b1;
        acc_reg = 8'h13;
      end
      S_RD_DATA: begin
        acc_st  = 1'b1;
        acc_rw  = 1'b1;
        acc_reg = 8'h14 + {5'd0, idx_q};
      end
      default: ;
    endcase
  end

  // The timer counts from the req cycle, so the last legal cycle is TIMEOUT-1.
  assign tmo      = (tmr_q == TIMEOUT - 1);
  assign txn_err  = wait_q && (i2c_err || (!i2c_done && tmo));
  assign txn_done = wait_q && i2c_done && !i2c_err;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shd_d   = shd_q;
    col_d   = col_q;
    cv_d    = 1'b0;
    req_d   = 1'b0;
    rw_d    = rw_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;

    if (acc_st) begin
      if (wait_q) begin
        tmr_d = tmr_q + 32'd1;
        if (txn_err) begin
          state_d = S_FAULT;
          wait_d  = 1'b0;
        end else if (txn_done) begin
          wait_d = 1'b0;
          case (state_q)
            S_WR_PON: begin
              state_d = S_PON_DLY;
              tmr_d   = 32'd0;
            end
            S_WR_ATIME: state_d = S_WR_AEN;
            S_WR_AEN:   state_d = S_POLL;
            S_POLL: begin
              if (i2c_rdata[0]) begin
                state_d = S_RD_DATA;
                idx_d   = 3'd0;
              end else begin
                state_d = S_GAP;
                tmr_d   = 32'd0;
              end
            end
            S_RD_DATA: begin
              shd_d[idx_q] = i2c_rdata;
              if (idx_q == 3'd7) state_d = S_PUBLISH;
              else               idx_d   = idx_q + 3'd1;
            end
            default: ;
          endcase
          // A dropped run lets the current access finish, then abandons the frame.
          if (!run) state_d = S_IDLE;
        end
      end else if (!run) begin
        state_d = S_IDLE;
      end else begin
        req_d   = 1'b1;
        wait_d  = 1'b1;
        tmr_d   = 32'd0;
        rw_d    = acc_rw;
        cmd_d   = 8'h80 | acc_reg;
        wdata_d = acc_wdata;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_d = 1'b0;
          tmr_d  = 32'd0;
          if (run) state_d = S_WR_PON;
        end
        S_PON_DLY: begin
          if (!run) begin
            state_d = S_IDLE;
            tmr_d   = 32'd0;
          end else if (tmr_q == PON_WAIT - 1) begin
            state_d = S_WR_ATIME;
            tmr_d   = 32'd0;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
        S_GAP: begin
          if (!run) begin
            state_d = S_IDLE;
            tmr_d   = 32'd0;
          end else if (tmr_q == POLL_GAP - 1) begin
            state_d = S_POLL;
            tmr_d   = 32'd0;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
        S_PUBLISH: state_d = run ? S_POLL : S_IDLE;
        S_FAULT: begin
          wait_d = 1'b0;
          tmr_d  = 32'd0;
          if (!run) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Words and color_valid become visible together in the PUBLISH cycle.
    if (state_d == S_PUBLISH) begin
      col_d = shd_d;
      cv_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      tmr_q   <= 32'd0;
      idx_q   <= 3'd0;
      shd_q   <= '0;
      col_q   <= 64'd0;
      cv_q    <= 1'b0;
      req_q   <= 1'b0;
      rw_q    <= 1'b0;
      cmd_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shd_q   <= shd_d;
      col_q   <= col_d;
      cv_q    <= cv_d;
      req_q   <= req_d;
      rw_q    <= rw_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
    end
  end

  assign i2c_req     = req_q;
  assign i2c_rw      = rw_q;
  assign i2c_cmd     = cmd_q;
  assign i2c_wdata   = wdata_q;
  assign clear_o     = col_q[15:0];
  assign red_o       = col_q[31:16];
  assign green_o     = col_q[47:32];
  assign blue_o      = col_q[63:48];
  assign color_valid = cv_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_tcs34725_sequencer.sv
// Bench for tcs34725_sequencer: an I2C engine model answers each req from a
// response queue; expected transactions and colour frames are scoreboarded.
module tb_tcs34725_sequencer;

  localparam int unsigned PON_WAIT = 40;
  localparam int unsigned POLL_GAP = 25;
  localparam int unsigned TIMEOUT  = 60;
  localparam int          LAT      = 3;
  localparam logic [1:0]  R_DONE = 2'd0, R_ERR = 2'd1, R_NONE = 2'd2, R_BOTH = 2'd3;

  logic        clk = 1'b0;
  logic        rst, run;
  logic        i2c_req, i2c_rw;
  logic [7:0]  i2c_cmd, i2c_wdata, i2c_rdata;
  logic        i2c_done, i2c_err;
  logic [15:0] clear_o, red_o, green_o, blue_o;
  logic        color_valid, busy, fault;

  tcs34725_sequencer #(
    .ATIME_VAL (8'hF6),
    .PON_WAIT  (PON_WAIT),
    .POLL_GAP  (POLL_GAP),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .i2c_req     (i2c_req),
    .i2c_rw      (i2c_rw),
    .i2c_cmd     (i2c_cmd),
    .i2c_wdata   (i2c_wdata),
    .i2c_rdata   (i2c_rdata),
    .i2c_done    (i2c_done),
    .i2c_err     (i2c_err),
    .clear_o     (clear_o),
    .red_o       (red_o),
    .green_o     (green_o),
    .blue_o      (blue_o),
    .color_valid (color_valid),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [16:0] exp_txn_q[$];
  logic [9:0]  resp_q[$];
  logic [63:0] exp_col_q[$];
  int          req_cyc_q[$];
  int          req_cnt = 0;
  int          cv_cnt = 0;
  int          last_req_cyc = 0;
  int          fault_cyc = 0;
  logic [7:0]  last_cmd = 8'h00;

  task automatic txn(input logic rw, input logic [7:0] cmd, input logic [7:0] wd,
                     input logic [1:0] kind, input logic [7:0] rdat);
    exp_txn_q.push_back({rw, cmd, wd});
    resp_q.push_back({kind, rdat});
  endtask

  task automatic startup_txns();
    txn(1'b0, 8'h80, 8'h01, R_DONE, 8'h00);
    txn(1'b0, 8'h81, 8'hF6, R_DONE, 8'h00);
    txn(1'b0, 8'h80, 8'h03, R_DONE, 8'h00);
  endtask

  // Engine model: checks each request against the scoreboard and answers it.
  initial begin : engine
    logic [16:0] e;
    logic [9:0]  r;
    logic [8:0]  held;
    i2c_done  = 1'b0;
    i2c_err   = 1'b0;
    i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (i2c_req === 1'b1) begin
        req_cnt++;
        last_req_cyc = cyc;
        last_cmd     = i2c_cmd;
        req_cyc_q.push_back(cyc);
        held = {i2c_rw, i2c_cmd};
        check_eq("req_expected", 64'(exp_txn_q.size() != 0), 64'd1);
        if (exp_txn_q.size() != 0) begin
          e = exp_txn_q.pop_front();
          if (e[16]) check_eq("rd_txn", 64'({i2c_rw, i2c_cmd}), 64'(e[16:8]));
          else       check_eq("wr_txn", 64'({i2c_rw, i2c_cmd, i2c_wdata}), 64'(e));
        end
        r = (resp_q.size() != 0) ? resp_q.pop_front() : {R_DONE, 8'h00};
        @(negedge clk);
        check_eq("req_1cyc", 64'(i2c_req), 64'd0);
        repeat (LAT - 1) @(negedge clk);
        if (r[9:8] != R_NONE) begin
          check_eq("txn_hold", 64'({i2c_rw, i2c_cmd}), 64'(held));
          i2c_rdata = r[7:0];
          i2c_done  = (r[9:8] != R_ERR);
          i2c_err   = (r[9:8] != R_DONE);
          @(negedge clk);
          i2c_done  = 1'b0;
          i2c_err   = 1'b0;
        end
      end
    end
  end

  // Output monitor: colour frames against the scoreboard, fault rising edge time.
  initial begin : monitor
    logic [63:0] ec;
    logic        fault_prev;
    fault_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (color_valid === 1'b1) begin
        cv_cnt++;
        check_eq("cv_expected", 64'(exp_col_q.size() != 0), 64'd1);
        if (exp_col_q.size() != 0) begin
          ec = exp_col_q.pop_front();
          check_eq("color_words", {blue_o, green_o, red_o, clear_o}, ec);
        end
      end
      if (fault === 1'b1 && fault_prev !== 1'b1) fault_cyc = cyc;
      fault_prev = fault;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  localparam logic [63:0] FRAME1 = {16'h8877, 16'h6655, 16'h4433, 16'h2211};

  initial begin : main
    int base_cv;
    int rc;
    logic [7:0] b, c;

    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req",   64'(i2c_req), 64'd0);
    check_eq("rst_cmd",   64'({i2c_rw, i2c_cmd, i2c_wdata}), 64'd0);
    check_eq("rst_busy",  64'(busy), 64'd0);
    check_eq("rst_fault", 64'(fault), 64'd0);
    check_eq("rst_cv",    64'(color_valid), 64'd0);
    check_eq("rst_words", {blue_o, green_o, red_o, clear_o}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Startup, two empty polls, one valid poll, one frame, then one more poll.
    startup_txns();
    txn(1'b1, 8'h93, 8'h00, R_DONE, 8'h00);
    txn(1'b1, 8'h93, 8'h00, R_DONE, 8'h00);
    txn(1'b1, 8'h93, 8'h00, R_DONE, 8'h01);
    for (int i = 0; i < 8; i++) begin
      c = 8'(8'h94 + i);
      b = 8'(8'h11 * (i + 1));
      txn(1'b1, c, 8'h00, R_DONE, b);
    end
    exp_col_q.push_back(FRAME1);
    txn(1'b1, 8'h93, 8'h00, R_DONE, 8'h00);
    req_cyc_q.delete();
    base_cv = cv_cnt;
    run = 1'b1;
    for (int i = 0; i < 3000 && exp_txn_q.size() != 0; i++) @(negedge clk);
    check_eq("s1_all_txn", 64'(exp_txn_q.size()), 64'd0);
    repeat (8) @(negedge clk);
    check_eq("s1_busy_run", 64'(busy), 64'd1);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("s1_busy_idle", 64'(busy), 64'd0);
    check_eq("s1_cv_count", 64'(cv_cnt - base_cv), 64'd1);
    check_eq("s1_clear", 64'(clear_o), 64'h2211);
    check_eq("s1_red",   64'(red_o),   64'h4433);
    check_eq("s1_green", 64'(green_o), 64'h6655);
    check_eq("s1_blue",  64'(blue_o),  64'h8877);
    check_eq("s1_req_n", 64'(req_cyc_q.size()), 64'd15);
    check_eq("s1_pon_gap",  64'((req_cyc_q[1] - req_cyc_q[0]) >= int'(PON_WAIT)), 64'd1);
    check_eq("s1_poll_gap1", 64'((req_cyc_q[4] - req_cyc_q[3]) >= int'(POLL_GAP)), 64'd1);
    check_eq("s1_poll_gap2", 64'((req_cyc_q[5] - req_cyc_q[4]) >= int'(POLL_GAP)), 64'd1);

    // NACK on the ATIME write: fault, no further traffic, run=0 clears it.
    txn(1'b0, 8'h80, 8'h01, R_DONE, 8'h00);
    txn(1'b0, 8'h81, 8'hF6, R_ERR, 8'h00);
    run = 1'b1;
    for (int i = 0; i < 1000 && fault !== 1'b1; i++) @(negedge clk);
    check_eq("s2_fault", 64'(fault), 64'd1);
    check_eq("s2_busy",  64'(busy), 64'd0);
    rc = req_cnt;
    repeat (100) @(negedge clk);
    check_eq("s2_no_req", 64'(req_cnt), 64'(rc));
    check_eq("s2_fault_sticky", 64'(fault), 64'd1);
    check_eq("s2_words_kept", {blue_o, green_o, red_o, clear_o}, FRAME1);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("s2_fault_clr", 64'(fault), 64'd0);

    // Engine silent on the 0x16 read: fault exactly TIMEOUT cycles after req.
    startup_txns();
    txn(1'b1, 8'h93, 8'h00, R_DONE, 8'h01);
    txn(1'b1, 8'h94, 8'h00, R_DONE, 8'hAA);
    txn(1'b1, 8'h95, 8'h00, R_DONE, 8'hBB);
    txn(1'b1, 8'h96, 8'h00, R_NONE, 8'h00);
    base_cv = cv_cnt;
    run = 1'b1;
    for (int i = 0; i < 2000 && fault !== 1'b1; i++) @(negedge clk);
    check_eq("s3_fault", 64'(fault), 64'd1);
    check_eq("s3_last_cmd", 64'(last_cmd), 64'h96);
    check_eq("s3_timeout", 64'(fault_cyc - last_req_cyc), 64'(TIMEOUT));
    check_eq("s3_words_kept", {blue_o, green_o, red_o, clear_o}, FRAME1);
    check_eq("s3_no_cv", 64'(cv_cnt - base_cv), 64'd0);
    run = 1'b0;
    repeat (2) @(negedge clk);

    // run dropped while idx=3 is outstanding: read completes, no publish.
    startup_txns();
    txn(1'b1, 8'h93, 8'h00, R_DONE, 8'h01);
    for (int i = 0; i < 4; i++) begin
      c = 8'(8'h94 + i);
      b = 8'(i + 1);
      txn(1'b1, c, 8'h00, R_DONE, b);
    end
    base_cv = cv_cnt;
    run = 1'b1;
    for (int i = 0; i < 2000 && exp_txn_q.size() != 0; i++) @(negedge clk);
    run = 1'b0;
    check_eq("s4_last_cmd", 64'(last_cmd), 64'h97);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
    rc = req_cnt;
    repeat (20) @(negedge clk);
    check_eq("s4_busy", 64'(busy), 64'd0);
    check_eq("s4_fault", 64'(fault), 64'd0);
    check_eq("s4_no_req", 64'(req_cnt), 64'(rc));
    check_eq("s4_resp_used", 64'(resp_q.size()), 64'd0);
    check_eq("s4_no_cv", 64'(cv_cnt - base_cv), 64'd0);
    check_eq("s4_words_kept", {blue_o, green_o, red_o, clear_o}, FRAME1);

    // Same-cycle done and err on the first write: err wins.
    txn(1'b0, 8'h80, 8'h01, R_BOTH, 8'h00);
    run = 1'b1;
    for (int i = 0; i < 200 && fault !== 1'b1; i++) @(negedge clk);
    check_eq("s5_fault", 64'(fault), 64'd1);
    check_eq("s5_busy", 64'(busy), 64'd0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("s5_fault_clr", 64'(fault), 64'd0);
    check_eq("s5_txn_left", 64'(exp_txn_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
